// File: rtl/alu_mismatch_monitor.sv
// Compares a reference ALU against an ALU under test, counts vectors/mismatches/triggers
// and keeps mismatching vectors in a show-ahead record FIFO.
//   state  | meaning
//   IDLE   | not accepting vectors, waiting for start
//   RUN    | accepting vectors
//   HALTED | stopped after a mismatch with halt_en set, waiting for start
module alu_mismatch_monitor #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          clear,
   input  logic                          halt_en,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [3:0]                    in_a,
   input  logic [3:0]                    in_b,
   input  logic [1:0]                    in_op,
   input  logic [3:0]                    clean_res,
   input  logic [3:0]                    trojan_res,
   input  logic [2:0]                    clean_flg,
   input  logic [2:0]                    trojan_flg,
   input  logic                          rd_en,
   output logic                          rd_valid,
   output logic [23:0]                   rd_data,
   output logic [CNT_W-1:0]              test_count,
   output logic [CNT_W-1:0]              mismatch_count,
   output logic [CNT_W-1:0]              trigger_count,
   output logic [CNT_W-1:0]              drop_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [1:0]                    state_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_HALTED = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_s1_valid;
   logic             r_s1_mis;
   logic [23:0]      r_s1_rec;

   logic [23:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;

   logic [CNT_W-1:0] r_test_cnt;
   logic [CNT_W-1:0] r_mis_cnt;
   logic [CNT_W-1:0] r_trig_cnt;
   logic [CNT_W-1:0] r_drop_cnt;

   logic             w_accept;
   logic             w_mis_in;
   logic             w_push;
   logic             w_full;
   logic             w_pop;
   logic             w_wr;
   logic             w_drop;
   logic             w_trig;

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign in_ready = (r_state == S_RUN) && !(r_s1_valid && r_s1_mis && halt_en);
   assign w_accept = in_valid && in_ready && !clear;
   assign w_mis_in = (clean_res != trojan_res) || (clean_flg != trojan_flg);

   // Stage 2 is the edge after acceptance: counting, pushing and halting happen there.
   assign w_push = r_s1_valid && r_s1_mis;
   assign w_trig = r_s1_rec[23:14] == {4'hF, 4'hF, 2'b00};
   assign w_full = (r_level == LVL_FULL);
   assign w_pop  = rd_en && rd_valid;
   assign w_wr   = w_push && (!w_full || w_pop);
   assign w_drop = w_push && w_full && !w_pop;

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_RUN;
            S_RUN:    if (w_push && halt_en) w_state_nxt = S_HALTED;
            S_HALTED: if (start) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_s1_valid <= 1'b0;
         r_s1_mis   <= 1'b0;
         r_s1_rec   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_mis <= w_mis_in;
            r_s1_rec <= {in_a, in_b, in_op, clean_res, clean_flg, trojan_res, trojan_flg};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_test_cnt <= '0;
         r_mis_cnt  <= '0;
         r_trig_cnt <= '0;
         r_drop_cnt <= '0;
      end else if (clear) begin
         r_test_cnt <= '0;
         r_mis_cnt  <= '0;
         r_trig_cnt <= '0;
         r_drop_cnt <= '0;
      end else if (r_s1_valid) begin
         r_test_cnt <= f_sat_inc(r_test_cnt);
         if (r_s1_mis) r_mis_cnt  <= f_sat_inc(r_mis_cnt);
         if (w_trig)   r_trig_cnt <= f_sat_inc(r_trig_cnt);
         if (w_drop)   r_drop_cnt <= f_sat_inc(r_drop_cnt);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // When full with a simultaneous pop, wptr equals rptr: the head is read out this
   // cycle before the new record overwrites its slot.
   always_ff @(posedge clk) begin
      if (!clear && w_wr) r_mem[r_wptr] <= r_s1_rec;
   end

   assign rd_valid       = (r_level != '0);
   assign rd_data        = rd_valid ? r_mem[r_rptr] : 24'h0;
   assign fifo_level     = r_level;
   assign test_count     = r_test_cnt;
   assign mismatch_count = r_mis_cnt;
   assign trigger_count  = r_trig_cnt;
   assign drop_count     = r_drop_cnt;
   assign state_o        = r_state;

endmodule

// File: tb/tb_alu_mismatch_monitor.sv
// Self-checking bench for alu_mismatch_monitor: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_alu_mismatch_monitor;
   localparam int DEPTH = 8;
   localparam int CNT_W = 16;
   localparam int MAXC  = 65535;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, clear = 1'b0, halt_en = 1'b0, in_valid = 1'b0, rd_en = 1'b0;
   logic [3:0] in_a = '0, in_b = '0, clean_res = '0, trojan_res = '0;
   logic [1:0] in_op = '0;
   logic [2:0] clean_flg = '0, trojan_flg = '0;
   logic in_ready, rd_valid;
   logic [23:0] rd_data;
   logic [CNT_W-1:0] test_count, mismatch_count, trigger_count, drop_count;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [1:0] state_o;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   alu_mismatch_monitor #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .halt_en(halt_en),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .clean_res(clean_res), .trojan_res(trojan_res), .clean_flg(clean_flg),
      .trojan_flg(trojan_flg), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
      .test_count(test_count), .mismatch_count(mismatch_count),
      .trigger_count(trigger_count), .drop_count(drop_count),
      .fifo_level(fifo_level), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: state as 0/1/2, one pending accepted vector, record queue,
   // unbounded integer counters saturated only when compared.
   int          m_state = 0;
   bit          m_pv = 0, m_pm = 0, m_ptrig = 0;
   logic [23:0] m_prec = '0;
   logic [23:0] m_q[$];
   int          m_test = 0, m_mis = 0, m_trig = 0, m_drop = 0;

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   function automatic bit m_ready();
      return (m_state == 1) && !(m_pv && m_pm && halt_en);
   endfunction

   task automatic m_reset();
      m_state = 0; m_pv = 0; m_pm = 0; m_ptrig = 0; m_prec = '0;
      m_q.delete();
      m_test = 0; m_mis = 0; m_trig = 0; m_drop = 0;
   endtask

   always @(posedge clk or posedge rst) begin : model
      bit acc, popd;
      int sz0;
      if (rst || clear) begin
         m_reset();
      end else begin
         acc  = in_valid && m_ready();
         sz0  = m_q.size();
         popd = rd_en && (sz0 > 0);
         if (popd) void'(m_q.pop_front());
         if (m_pv) begin
            m_test++;
            if (m_ptrig) m_trig++;
            if (m_pm) begin
               m_mis++;
               if (sz0 == DEPTH && !popd) m_drop++;
               else m_q.push_back(m_prec);
            end
         end
         if (m_state == 0 && start) m_state = 1;
         else if (m_state == 1 && m_pv && m_pm && halt_en) m_state = 2;
         else if (m_state == 2 && start) m_state = 1;
         m_pv = acc;
         if (acc) begin
            m_pm    = (clean_res != trojan_res) || (clean_flg != trojan_flg);
            m_ptrig = (in_a == 4'hF) && (in_b == 4'hF) && (in_op == 2'b00);
            m_prec  = {in_a, in_b, in_op, clean_res, clean_flg, trojan_res, trojan_flg};
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("in_ready", 32'(in_ready), 32'(m_ready()));
         check("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
         check("rd_data", 32'(rd_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
         check("test_count", 32'(test_count), 32'(sat(m_test)));
         check("mismatch_count", 32'(mismatch_count), 32'(sat(m_mis)));
         check("trigger_count", 32'(trigger_count), 32'(sat(m_trig)));
         check("drop_count", 32'(drop_count), 32'(sat(m_drop)));
         check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
         check("state", 32'(state_o), 32'(m_state));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic set_vec(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input logic [3:0] cr, input logic [2:0] cf,
                          input logic [3:0] tr, input logic [2:0] tf);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
      clean_res = cr; clean_flg = cf; trojan_res = tr; trojan_flg = tf;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(state_o), 32'h0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'h0);
      check({tag, "_test"}, 32'(test_count), 32'h0);
      check({tag, "_mis"}, 32'(mismatch_count), 32'h0);
      check({tag, "_trig"}, 32'(trigger_count), 32'h0);
      check({tag, "_drop"}, 32'(drop_count), 32'h0);
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
      check({tag, "_level"}, 32'(fifo_level), 32'h0);
      check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
   endtask

   logic [23:0] recs [10];
   logic [23:0] rx, exp_rec;
   logic [3:0]  a, b, cr, tr;
   logic [1:0]  op;
   logic [2:0]  cf, tf;
   logic [9:0]  idx;

   initial begin
      #2;
      check_reset_outputs("rst0");
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;
      tick();

      // Exhaustive a/b/op sweep with identical responses.
      pulse_start();
      for (int i = 0; i < 1024; i++) begin
         idx = 10'(i);
         cr = 4'($urandom); cf = 3'($urandom);
         set_vec(idx[3:0], idx[7:4], idx[9:8], cr, cf, cr, cf);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      check("sweep_test", 32'(test_count), 32'd1024);
      check("sweep_mis", 32'(mismatch_count), 32'd0);
      check("sweep_trig", 32'(trigger_count), 32'd1);
      check("sweep_rd_valid", 32'(rd_valid), 32'd0);

      // Halt on the trigger vector.
      pulse_clear();
      halt_en = 1'b1;
      pulse_start();
      cf = 3'($urandom); tf = 3'($urandom);
      set_vec(4'hF, 4'hF, 2'b00, 4'hE, cf, 4'h0, tf);
      tick();
      set_vec(4'h3, 4'h4, 2'b01, 4'h1, 3'b000, 4'h2, 3'b000);
      tick(); tick(); tick();
      in_valid = 1'b0;
      tick();
      exp_rec = {4'hF, 4'hF, 2'b00, 4'hE, cf, 4'h0, tf};
      check("halt_mis", 32'(mismatch_count), 32'd1);
      check("halt_trig", 32'(trigger_count), 32'd1);
      check("halt_test", 32'(test_count), 32'd1);
      check("halt_state", 32'(state_o), 32'd2);
      check("halt_in_ready", 32'(in_ready), 32'd0);
      check("halt_rd_data", 32'(rd_data), 32'(exp_rec));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      check("halt_pop_rd_valid", 32'(rd_valid), 32'd0);
      check("halt_pop_state", 32'(state_o), 32'd2);

      // Overflow: 10 mismatches into an 8-deep FIFO.
      pulse_clear();
      halt_en = 1'b0;
      pulse_start();
      for (int k = 0; k < 10; k++) begin
         a = 4'($urandom); b = 4'($urandom); op = 2'($urandom);
         cr = 4'($urandom); cf = 3'($urandom); tf = 3'($urandom);
         tr = cr ^ 4'(1 + $urandom_range(14));
         recs[k] = {a, b, op, cr, cf, tr, tf};
         set_vec(a, b, op, cr, cf, tr, tf);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      check("ovf_level", 32'(fifo_level), 32'd8);
      check("ovf_drop", 32'(drop_count), 32'd2);
      check("ovf_mis", 32'(mismatch_count), 32'd10);
      check("ovf_head", 32'(rd_data), 32'(recs[0]));

      // Full FIFO: push and pop on the same edge.
      a = 4'h5; b = 4'hA; op = 2'b10; cr = 4'h7; cf = 3'b101; tr = 4'h7; tf = 3'b001;
      rx = {a, b, op, cr, cf, tr, tf};
      set_vec(a, b, op, cr, cf, tr, tf);
      tick();
      in_valid = 1'b0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("fullpp_drop", 32'(drop_count), 32'd2);
      check("fullpp_level", 32'(fifo_level), 32'd8);
      for (int k = 1; k < 8; k++) begin
         check("order", 32'(rd_data), 32'(recs[k]));
         rd_en = 1'b1; tick(); rd_en = 1'b0;
      end
      check("order_last", 32'(rd_data), 32'(rx));
      rd_en = 1'b1; tick(); tick(); rd_en = 1'b0;
      check("drain_rd_valid", 32'(rd_valid), 32'd0);
      check("drain_level", 32'(fifo_level), 32'd0);

      // clear with a vector accepted the previous edge.
      set_vec(4'h1, 4'h2, 2'b11, 4'h3, 3'b000, 4'h4, 3'b000);
      tick();
      in_valid = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_test", 32'(test_count), 32'd0);
      check("clr_mis", 32'(mismatch_count), 32'd0);
      check("clr_level", 32'(fifo_level), 32'd0);
      check("clr_state", 32'(state_o), 32'd0);
      tick();
      check("clr_test_after", 32'(test_count), 32'd0);
      check("clr_rd_valid", 32'(rd_valid), 32'd0);

      // Saturation of all four counters.
      pulse_start();
      set_vec(4'hF, 4'hF, 2'b00, 4'h9, 3'b010, 4'h6, 3'b010);
      for (int i = 0; i < 65550; i++) tick();
      in_valid = 1'b0;
      tick(); tick();
      check("sat_test", 32'(test_count), 32'hFFFF);
      check("sat_mis", 32'(mismatch_count), 32'hFFFF);
      check("sat_trig", 32'(trigger_count), 32'hFFFF);
      check("sat_drop", 32'(drop_count), 32'hFFFF);
      check("sat_level", 32'(fifo_level), 32'd8);
      pulse_clear();

      // Random traffic against the model.
      pulse_start();
      for (int i = 0; i < 3000; i++) begin
         a = 4'($urandom); b = 4'($urandom); op = 2'($urandom);
         if ($urandom_range(7) == 0) begin a = 4'hF; b = 4'hF; op = 2'b00; end
         cr = 4'($urandom); cf = 3'($urandom);
         tr = ($urandom_range(3) == 0) ? 4'($urandom) : cr;
         tf = ($urandom_range(3) == 0) ? 3'($urandom) : cf;
         set_vec(a, b, op, cr, cf, tr, tf);
         in_valid = ($urandom_range(3) != 0);
         rd_en    = ($urandom_range(2) == 0);
         start    = ($urandom_range(19) == 0);
         clear    = ($urandom_range(299) == 0);
         if ($urandom_range(49) == 0) halt_en = ~halt_en;
         tick();
      end
      in_valid = 1'b0; rd_en = 1'b0; start = 1'b0; clear = 1'b0;
      tick();

      // Asynchronous reset with records stored and a vector in flight.
      pulse_clear();
      halt_en = 1'b0;
      pulse_start();
      for (int k = 0; k < 6; k++) begin
         set_vec(4'(k), 4'(k + 3), 2'(k), 4'h8, 3'b100, 4'h1, 3'b100);
         tick();
      end
      check("pre_rst_level", 32'(fifo_level), 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_async");
      tick(); tick();
      rst = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      check("post_rst_test", 32'(test_count), 32'd0);
      check("post_rst_level", 32'(fifo_level), 32'd0);
      check("post_rst_state", 32'(state_o), 32'd0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_mismatch_monitor.md
ALU_MISMATCH_MONITOR -- requirements
Module: alu_mismatch_monitor

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, mismatch-record FIFO entries (power of 2, >=2).
REQ-002 Parameter: CNT_W, 16, width of every statistic counter.
REQ-003 Single clock domain; reset asynchronous, active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  pulse: IDLE->RUN, or HALTED->RUN.
REQ-007 clear  in  1  pulse: zero counters, flush FIFO and pipeline, go IDLE.
REQ-008 halt_en  in  1  1 = stop accepting vectors after first mismatch.
REQ-009 in_valid  in  1  vector and both ALU responses present.
REQ-010 in_ready  out  1  monitor accepts vector this cycle.
REQ-011 in_a, in_b  in  4 each  ALU operands.
REQ-012 in_op  in  2  ALU opcode.
REQ-013 clean_res, trojan_res  in  4 each  results of reference ALU and ALU under test.
REQ-014 clean_flg, trojan_flg  in  3 each  {carry, zero, overflow}.
REQ-015 rd_en  in  1  pop head record.
REQ-016 rd_valid  out  1  FIFO non-empty.
REQ-017 rd_data  out  24  head record {in_a, in_b, in_op, clean_res, clean_flg, trojan_res, trojan_flg}, MSB first.
REQ-018 test_count, mismatch_count, trigger_count, drop_count  out  CNT_W each  statistics.
REQ-019 fifo_level  out  $clog2(FIFO_DEPTH)+1  records stored.
REQ-020 state_o  out  2  00 IDLE, 01 RUN, 10 HALTED.

Function
REQ-021 FSM states IDLE, RUN, HALTED; IDLE->RUN on start; RUN->HALTED when a mismatching vector reaches stage 2 with halt_en=1; HALTED->RUN on start; any state->IDLE on clear.
REQ-022 in_ready = (state==RUN) AND NOT (stage-1 valid AND stage-1 mismatch AND halt_en); exactly one mismatching vector accepted before halt.
REQ-023 Accept = in_valid AND in_ready at rising edge N; stage 1 registers inputs and mismatch = (res differ) OR (flg differ) at edge N.
REQ-024 At edge N+1: test_count +1; mismatch_count +1 if mismatch; trigger_count +1 if in_a=4'hF, in_b=4'hF, in_op=2'b00 (independent of mismatch); record pushed if mismatch.
REQ-025 All counters saturate at all-ones; no wrap.
REQ-026 Push while FIFO full and no pop same edge: record dropped, drop_count +1, stored records unchanged; mismatch_count still increments.
REQ-027 Push and pop on same edge while full: both succeed, no drop, fifo_level unchanged.
REQ-028 Show-ahead FIFO: rd_data valid combinationally whenever rd_valid=1; rd_en with rd_valid pops at edge; rd_en while empty ignored, no underflow.
REQ-029 Read-side pops allowed in every state, including IDLE and HALTED.
REQ-030 clear has priority over start and over any in-flight vector; in-flight stage-1 vector discarded, not counted.
REQ-031 Read and write pointers wrap modulo FIFO_DEPTH; records pop in push order.

Reset
REQ-032 rst asserted: state IDLE, in_ready 0, all counters 0, FIFO empty (rd_valid 0, fifo_level 0), stage 1 invalid, rd_data 0.
REQ-033 rst asserted mid-operation: in-flight vector and stored records lost; no count update on the following edge.

Verification
REQ-034 start; 1024 vectors (all a,b,op), identical responses -> test_count=1024, mismatch_count=0, trigger_count=1, rd_valid=0.
REQ-035 halt_en=1; vector a=F,b=F,op=00 with trojan_res=0, clean_res=E -> mismatch_count=1, trigger_count=1, state HALTED, in_ready=0, rd_data={F,F,00,E,clean_flg,0,trojan_flg}.
REQ-036 halt_en=0; 10 mismatching vectors, no reads, FIFO_DEPTH=8 -> fifo_level=8, drop_count=2, mismatch_count=10, first 8 records read back in order.
REQ-037 FIFO full, mismatching vector and rd_en on same edge -> drop_count unchanged, fifo_level=8.
REQ-038 clear asserted with vector accepted previous edge -> counters 0, FIFO empty, state IDLE, vector not counted.
REQ-039 rst asserted mid-stream with records stored -> all outputs per REQ-032 immediately, no clock required.
